// File: rtl/bcd_7seg_encoder.sv
// Binary count -> six 7-segment digits via serial double-dabble, BIT_SIZE+2 cycles per conversion.
// No backpressure: a strobe while busy lands in a one-deep pending slot (latest wins).
module bcd_7seg_encoder #(
  parameter int BIT_SIZE       = 20,
  parameter int SEGMENTOS      = 7,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLANK_LZ       = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BIT_SIZE-1:0] count_in,
  input  logic                count_valid,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic [0:SEGMENTOS-1] un,
  output logic [0:SEGMENTOS-1] dec,
  output logic [0:SEGMENTOS-1] cen,
  output logic [0:SEGMENTOS-1] un_millar,
  output logic [0:SEGMENTOS-1] dec_millar,
  output logic [0:SEGMENTOS-1] cen_millar
);

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;
  typedef logic [0:SEGMENTOS-1] seg_t;

  localparam int CW = $clog2(BIT_SIZE + 1);
  localparam int EW = (BIT_SIZE > 20) ? BIT_SIZE : 20;
  localparam logic [EW-1:0] MAX_DISP = EW'(999999);
  localparam seg_t SEG_BLANK = seg_t'((SEG_ACTIVE_LOW != 0) ? 7'b1111111 : 7'b0000000);
  localparam seg_t SEG_DASH  = seg_t'((SEG_ACTIVE_LOW != 0) ? 7'b1111110 : 7'b0000001);

  function automatic seg_t seg_of(input logic [3:0] d);
    logic [0:6] p;
    case (d)
      4'd0:    p = 7'b1111110;
      4'd1:    p = 7'b0110000;
      4'd2:    p = 7'b1101101;
      4'd3:    p = 7'b1111001;
      4'd4:    p = 7'b0110011;
      4'd5:    p = 7'b1011011;
      4'd6:    p = 7'b1011111;
      4'd7:    p = 7'b1110000;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1111011;
      default: p = 7'b0000000;
    endcase
    return (SEG_ACTIVE_LOW != 0) ? seg_t'(~p) : seg_t'(p);
  endfunction

  state_t              state;
  logic [CW-1:0]       bit_cnt;
  logic [BIT_SIZE-1:0] shreg;
  logic [23:0]         bcd;
  logic                ovf_cap;
  logic                pend_vld;
  logic [BIT_SIZE-1:0] pend_dat;
  logic                enc_ph;
  seg_t                stg_seg [6];
  logic                stg_ovf;
  seg_t                dig_q [6];

  logic [BIT_SIZE-1:0] start_dat;
  logic                start_ovf;
  logic [23:0]         bcd_adj;
  logic [23:0]         bcd_nxt;
  logic [2:0]          hi_nz;
  seg_t                pat [6];

  assign start_dat = pend_vld ? pend_dat : count_in;
  assign start_ovf = EW'(start_dat) > MAX_DISP;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 6; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    bcd_nxt = (bcd_adj << 1) | 24'(shreg[BIT_SIZE-1]);
  end

  // Digits above the most significant non-zero one are blanked; units always shows.
  always_comb begin
    hi_nz = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (bcd[i*4 +: 4] != 4'd0) hi_nz = 3'(i);
    end
    for (int i = 0; i < 6; i++) begin
      if (ovf_cap)                            pat[i] = SEG_DASH;
      else if (BLANK_LZ != 0 && 3'(i) > hi_nz) pat[i] = SEG_BLANK;
      else                                    pat[i] = seg_of(bcd[i*4 +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      bcd      <= '0;
      ovf_cap  <= 1'b0;
      pend_vld <= 1'b0;
      pend_dat <= '0;
      enc_ph   <= 1'b0;
      stg_ovf  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        stg_seg[i] <= SEG_BLANK;
        dig_q[i]   <= SEG_BLANK;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_vld || count_valid) begin
            shreg   <= start_dat;
            ovf_cap <= start_ovf;
            bcd     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
            // Pending slot is consumed; a coincident strobe refills it.
            if (pend_vld) begin
              pend_vld <= count_valid;
              if (count_valid) pend_dat <= count_in;
            end
          end
        end
        SHIFT: begin
          bcd     <= bcd_nxt;
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == CW'(BIT_SIZE - 1)) begin
            enc_ph <= 1'b0;
            state  <= ENCODE;
          end
        end
        ENCODE: begin
          // Decode is staged so the visible outputs only ever take a final value.
          if (!enc_ph) begin
            for (int i = 0; i < 6; i++) stg_seg[i] <= pat[i];
            stg_ovf <= ovf_cap;
            enc_ph  <= 1'b1;
          end else begin
            for (int i = 0; i < 6; i++) dig_q[i] <= stg_seg[i];
            ovf    <= stg_ovf;
            done   <= 1'b1;
            busy   <= 1'b0;
            enc_ph <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (state != IDLE && count_valid) begin
        pend_vld <= 1'b1;
        pend_dat <= count_in;
      end
    end
  end

  assign un         = dig_q[0];
  assign dec        = dig_q[1];
  assign cen        = dig_q[2];
  assign un_millar  = dig_q[3];
  assign dec_millar = dig_q[4];
  assign cen_millar = dig_q[5];

endmodule

// File: tb/tb_bcd_7seg_encoder.sv
// Directed bench for bcd_7seg_encoder: vector table plus pending, timing and reset sequences.
module tb_bcd_7seg_encoder;

  typedef logic [0:6] seg_t;

  localparam seg_t S0 = 7'b0000001;
  localparam seg_t S1 = 7'b1001111;
  localparam seg_t S2 = 7'b0010010;
  localparam seg_t S3 = 7'b0000110;
  localparam seg_t S4 = 7'b1001100;
  localparam seg_t S5 = 7'b0100100;
  localparam seg_t S6 = 7'b0100000;
  localparam seg_t S7 = 7'b0001111;
  localparam seg_t S8 = 7'b0000000;
  localparam seg_t S9 = 7'b0000100;
  localparam seg_t BL = 7'b1111111;
  localparam seg_t DS = 7'b1111110;

  typedef struct packed {
    logic [19:0] val;
    seg_t        cm;
    seg_t        dm;
    seg_t        um;
    seg_t        c;
    seg_t        d;
    seg_t        u;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] count_in;
  logic        count_valid;
  logic        busy, done, ovf;
  seg_t        un, dec, cen, un_millar, dec_millar, cen_millar;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bcd_7seg_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .count_in   (count_in),
    .count_valid(count_valid),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf),
    .un         (un),
    .dec        (dec),
    .cen        (cen),
    .un_millar  (un_millar),
    .dec_millar (dec_millar),
    .cen_millar (cen_millar)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic chk_vec(input string tag, input vec_t v);
    chk({tag, ".un"},  32'(un),         32'(v.u));
    chk({tag, ".dec"}, 32'(dec),        32'(v.d));
    chk({tag, ".cen"}, 32'(cen),        32'(v.c));
    chk({tag, ".um"},  32'(un_millar),  32'(v.um));
    chk({tag, ".dm"},  32'(dec_millar), 32'(v.dm));
    chk({tag, ".cm"},  32'(cen_millar), 32'(v.cm));
    chk({tag, ".ovf"}, 32'(ovf),        32'(v.ovf));
  endtask

  task automatic strobe(input logic [19:0] v);
    @(negedge clk);
    count_in    = v;
    count_valid = 1'b1;
    @(negedge clk);
    count_valid = 1'b0;
  endtask

  // Counts negedges until done is seen; an exhausted budget is a failed check.
  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) chk("done_timeout", 32'(cyc), 32'(budget + 1));
  endtask

  vec_t vecs [9];
  vec_t v;
  int   cyc;
  int   seen;

  initial begin
    vecs[0] = '{20'd1000,    BL, BL, S1, S0, S0, S0, 1'b0};
    vecs[1] = '{20'd999999,  S9, S9, S9, S9, S9, S9, 1'b0};
    vecs[2] = '{20'd1000000, DS, DS, DS, DS, DS, DS, 1'b1};
    vecs[3] = '{20'd0,       BL, BL, BL, BL, BL, S0, 1'b0};
    vecs[4] = '{20'd123456,  S1, S2, S3, S4, S5, S6, 1'b0};
    vecs[5] = '{20'd7080,    BL, BL, S7, S0, S8, S0, 1'b0};
    vecs[6] = '{20'd1048575, DS, DS, DS, DS, DS, DS, 1'b1};
    vecs[7] = '{20'd5,       BL, BL, BL, BL, BL, S5, 1'b0};
    vecs[8] = '{20'd900000,  S9, S0, S0, S0, S0, S0, 1'b0};

    rst = 1'b0; count_in = '0; count_valid = 1'b0;
    #12;
    v = '{20'd0, BL, BL, BL, BL, BL, BL, 1'b0};
    chk_vec("reset", v);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk_vec("idle", v);
    chk("idle.done", 32'(done), 32'd0);

    for (int i = 0; i < 9; i++) begin
      strobe(vecs[i].val);
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'd1);
      wait_done(40, cyc);
      chk($sformatf("v%0d.latency", i), 32'(cyc), 32'd22);
      chk_vec($sformatf("v%0d", i), vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d.done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("v%0d.busy_end", i), 32'(busy), 32'd0);
    end

    // Second strobe while busy is held and converted after one IDLE cycle.
    strobe(20'd10000);
    repeat (4) @(negedge clk);
    strobe(20'd100000);
    wait_done(40, cyc);
    chk_vec("pend.first", '{20'd0, BL, S1, S0, S0, S0, S0, 1'b0});
    @(negedge clk);
    wait_done(40, cyc);
    chk("pend.gap", 32'(cyc + 1), 32'd23);
    chk_vec("pend.second", '{20'd0, S1, S0, S0, S0, S0, S0, 1'b0});

    // Strobe sampled on the edge that completes ENCODE goes to pending.
    strobe(20'd7);
    repeat (20) @(negedge clk);
    strobe(20'd42);
    chk("enc_edge.done", 32'(done), 32'd1);
    chk_vec("enc_edge.first", '{20'd0, BL, BL, BL, BL, BL, S7, 1'b0});
    @(negedge clk);
    wait_done(40, cyc);
    chk("enc_edge.gap", 32'(cyc + 1), 32'd23);
    chk_vec("enc_edge.second", '{20'd0, BL, BL, BL, BL, S4, S2, 1'b0});

    // Reset mid-conversion with a pending value: asynchronous blanking, nothing resumes.
    strobe(20'd123456);
    repeat (3) @(negedge clk);
    strobe(20'd55);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk_vec("arst", '{20'd0, BL, BL, BL, BL, BL, BL, 1'b0});
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("arst.no_activity", 32'(seen), 32'd0);

    // Strobe presented with reset release is taken on the first edge.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    count_in = 20'd123456;
    count_valid = 1'b1;
    @(negedge clk);
    count_valid = 1'b0;
    wait_done(40, cyc);
    chk("release.latency", 32'(cyc), 32'd22);
    chk_vec("release", vecs[4]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
